// File: rtl/sunflower_pkg.sv
// Shared types and default widths for the sunflower sweep peak tracker.
// Contents:
//   spt_state_t  - tracker FSM states (IDLE, SWEEP)
//   SPT_*        - default parameter values used by sweep_peak_tracker
package sunflower_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } spt_state_t;

  localparam int SPT_DATA_W   = 12;
  localparam int SPT_POS_W    = 8;
  localparam int SPT_CNT_W    = 10;
  localparam int SPT_AVG_LOG2 = 2;

endpackage

// File: rtl/spt_group_avg.sv
// Group averager for the sweep peak tracker (used only when SPT_AVG_EN is defined).
// Sums 2**AVG_LOG2 consecutive accepted samples and presents their mean as a
// compare candidate on the group's final sample. The candidate position is
// the position of the group's first sample. A sweep ending mid-group flushes
// the partial sum, still divided by the full group size.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clear           drop any partial group (sweep start/restart)
//   in_valid        sample accepted into the current sweep this cycle
//   sample          raw ADC value
//   sample_pos      position of sample
//   last            accepted sample is the last of the sweep
//   cand_valid      combinational: candidate available this cycle
//   cand            combinational: group mean
//   cand_pos        combinational: position of the group's first sample
// AVG_LOG2 must be at least 1.
module spt_group_avg #(
  parameter int DATA_W   = 12,
  parameter int POS_W    = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [POS_W-1:0]  sample_pos,
  input  logic              last,
  output logic              cand_valid,
  output logic [DATA_W-1:0] cand,
  output logic [POS_W-1:0]  cand_pos
);

  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic [SUM_W-1:0]    acc;
  logic [AVG_LOG2-1:0] grp_cnt;
  logic [POS_W-1:0]    first_pos;
  logic [SUM_W-1:0]    sum_now;
  logic                grp_end;

  assign sum_now    = acc + {{AVG_LOG2{1'b0}}, sample};
  assign grp_end    = (grp_cnt == {AVG_LOG2{1'b1}}) || last;
  assign cand_valid = in_valid && grp_end;
  // Dropping the low AVG_LOG2 bits is the divide by the group size.
  assign cand       = sum_now[AVG_LOG2 +: DATA_W];
  // On the group's first sample the latch is not loaded yet, so bypass it.
  assign cand_pos   = (grp_cnt == '0) ? sample_pos : first_pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      grp_cnt   <= '0;
      first_pos <= '0;
    end else if (clear) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (in_valid) begin
      if (grp_end) begin
        acc     <= '0;
        grp_cnt <= '0;
      end else begin
        acc     <= sum_now;
        grp_cnt <= grp_cnt + 1'b1;
        if (grp_cnt == '0) first_pos <= sample_pos;
      end
    end
  end

endmodule

// File: rtl/sweep_peak_tracker.sv
// Sweep peak tracker: tracks the maximum ADC sample (and its panel position)
// over one controlled sweep and commits it when the sweep's last sample
// arrives. Committed results hold until the next commit.
// Optional feature: define SPT_AVG_EN to compare means of 2**AVG_LOG2-sample
// groups instead of raw samples.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   start         pulse: begin or restart a sweep (wins over sample_valid)
//   sample_valid  qualifies sample / sample_pos / sweep_last
//   sample        raw ADC value (unsigned)
//   sample_pos    position the sample was taken at
//   sweep_last    with sample_valid: final sample of the sweep
//   busy          sweep in progress
//   done          1-cycle pulse when a result is committed
//   peak_val      peak of the last completed sweep
//   peak_pos      position of peak_val
//   peak_valid    a sweep has completed since reset
//   sample_cnt    samples accepted in the last sweep (saturating)
//   cnt_ovf       last sweep saturated sample_cnt
// Handshake: a sample is consumed on every clock where the tracker is in
// SWEEP, sample_valid is high and start is low; there is no backpressure.
// The FSM state is held in the signal `state` for probing.
module sweep_peak_tracker
  import sunflower_pkg::*;
#(
  parameter int DATA_W   = SPT_DATA_W,
  parameter int POS_W    = SPT_POS_W,
  parameter int CNT_W    = SPT_CNT_W,
  parameter int AVG_LOG2 = SPT_AVG_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [POS_W-1:0]  sample_pos,
  input  logic              sweep_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] peak_val,
  output logic [POS_W-1:0]  peak_pos,
  output logic              peak_valid,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              cnt_ovf
);

  spt_state_t        state;
  logic [DATA_W-1:0] run_max;
  logic [POS_W-1:0]  run_pos;
  logic [CNT_W-1:0]  run_cnt;
  logic              run_ovf;

  logic              accept;
  logic              cand_valid;
  logic [DATA_W-1:0] cand;
  logic [POS_W-1:0]  cand_pos;

  logic              cnt_full;
  logic              take;
  logic [DATA_W-1:0] nxt_max;
  logic [POS_W-1:0]  nxt_pos;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              nxt_ovf;

  assign accept = (state == SWEEP) && sample_valid && !start;

`ifdef SPT_AVG_EN
  spt_group_avg #(
    .DATA_W  (DATA_W),
    .POS_W   (POS_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_group_avg (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .in_valid  (accept),
    .sample    (sample),
    .sample_pos(sample_pos),
    .last      (sweep_last),
    .cand_valid(cand_valid),
    .cand      (cand),
    .cand_pos  (cand_pos)
  );
`else
  logic [31:0] unused_avg_cfg;
  assign unused_avg_cfg = AVG_LOG2;
  assign cand_valid     = accept;
  assign cand           = sample;
  assign cand_pos       = sample_pos;
`endif

  // Next running values, including the current sample so a commit on the
  // last sample sees its own compare.
  always_comb begin
    cnt_full = (run_cnt == {CNT_W{1'b1}});
    take     = cand_valid && (cand > run_max);
    nxt_max  = take ? cand : run_max;
    nxt_pos  = take ? cand_pos : run_pos;
    nxt_cnt  = cnt_full ? run_cnt : run_cnt + 1'b1;
    // Overflow means a sample arrived with the counter already full.
    nxt_ovf  = run_ovf || cnt_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      run_max    <= '0;
      run_pos    <= '0;
      run_cnt    <= '0;
      run_ovf    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      peak_val   <= '0;
      peak_pos   <= '0;
      peak_valid <= 1'b0;
      sample_cnt <= '0;
      cnt_ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SWEEP;
            busy    <= 1'b1;
            run_max <= '0;
            run_pos <= '0;
            run_cnt <= '0;
            run_ovf <= 1'b0;
          end
        end
        SWEEP: begin
          if (start) begin
            // Restart: discard running state, committed outputs untouched.
            run_max <= '0;
            run_pos <= '0;
            run_cnt <= '0;
            run_ovf <= 1'b0;
          end else if (sample_valid) begin
            run_max <= nxt_max;
            run_pos <= nxt_pos;
            run_cnt <= nxt_cnt;
            run_ovf <= nxt_ovf;
            if (sweep_last) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              peak_valid <= 1'b1;
              peak_val   <= nxt_max;
              peak_pos   <= nxt_pos;
              sample_cnt <= nxt_cnt;
              cnt_ovf    <= nxt_ovf;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
